// File: rtl/audio_pkg.sv
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared audio constants: note phase increments at 48.8 kHz,
//                sound-effect ids and the arbiter state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package audio_pkg;

    localparam int PHASE_W = 32;

    // Phase increments for a 32-bit accumulator at the DAC sample rate
    localparam logic [PHASE_W-1:0] A4 = 32'd38702809;
    localparam logic [PHASE_W-1:0] B4 = 32'd43442408;
    localparam logic [PHASE_W-1:0] C5 = 32'd46025675;
    localparam logic [PHASE_W-1:0] D5 = 32'd51662093;
    localparam logic [PHASE_W-1:0] E5 = 32'd57988683;
    localparam logic [PHASE_W-1:0] F5 = 32'd61436839;
    localparam logic [PHASE_W-1:0] G5 = 32'd68960577;
    localparam logic [PHASE_W-1:0] A5 = 32'd77405618;
    localparam logic [PHASE_W-1:0] C6 = 32'd92051350;

    localparam int SFX_DROP     = 0;
    localparam int SFX_ROTATE   = 1;
    localparam int SFX_LINE     = 2;
    localparam int SFX_GAMEOVER = 3;

    localparam logic [PHASE_W-1:0] SFX_END = 32'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/sfx_arbiter_if.sv
// ============================================================================
//  Module      : sfx_arbiter_if
//  Description : Control, request and audio-path signals around sfx_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sfx_arbiter_if #(
    parameter int NUM_SFX = 4
);
    localparam int c_ID_W = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1;

    logic               enable;
    logic               mute;
    logic [NUM_SFX-1:0] sfx_req;
    logic [31:0]        mus_phase_inc;
    logic               mus_gate;
    logic [31:0]        phase_inc;
    logic               note_gate;
    logic               busy;
    logic [c_ID_W-1:0]  active_id;
    logic               sfx_done;

    modport master (
        output enable, mute, sfx_req, mus_phase_inc, mus_gate,
        input  phase_inc, note_gate, busy, active_id, sfx_done
    );

    modport slave (
        input  enable, mute, sfx_req, mus_phase_inc, mus_gate,
        output phase_inc, note_gate, busy, active_id, sfx_done
    );

endinterface

`default_nettype wire

// File: rtl/sfx_rom.sv
// ============================================================================
//  Module      : sfx_rom
//  Description : Note lists of the sound effects, one registered read per clk.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sfx_rom
    import audio_pkg::*;
#(
    parameter int ID_W   = 2,
    parameter int STEP_W = 3
) (
    input  wire logic              clk,
    input  wire logic [ID_W-1:0]   id,
    input  wire logic [STEP_W-1:0] step,
    output logic [PHASE_W-1:0]     phase_inc
);

    logic [PHASE_W-1:0] w_entry;

    // Any entry past the end of a list reads as the end marker
    always_comb begin
        w_entry = SFX_END;
        case (int'(id))
            SFX_DROP: begin
                if (int'(step) == 0) w_entry = C5;
            end
            SFX_ROTATE: begin
                case (int'(step))
                    0:       w_entry = E5;
                    1:       w_entry = G5;
                    default: w_entry = SFX_END;
                endcase
            end
            SFX_LINE: begin
                case (int'(step))
                    0:       w_entry = C5;
                    1:       w_entry = E5;
                    2:       w_entry = G5;
                    3:       w_entry = C6;
                    default: w_entry = SFX_END;
                endcase
            end
            SFX_GAMEOVER: begin
                case (int'(step))
                    0:       w_entry = E5;
                    1:       w_entry = D5;
                    2:       w_entry = C5;
                    3:       w_entry = B4;
                    4:       w_entry = A4;
                    default: w_entry = SFX_END;
                endcase
            end
            default: w_entry = SFX_END;
        endcase
    end

    always_ff @(posedge clk) begin
        phase_inc <= w_entry;
    end

endmodule

`default_nettype wire

// File: rtl/sfx_arbiter.sv
// ============================================================================
//  Module      : sfx_arbiter
//  Description : Plays prioritised sound effects from ROM, preempting the
//                music sequencer, and passes music through when idle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sfx_arbiter
    import audio_pkg::*;
#(
    parameter int NUM_SFX     = 4,
    parameter int STEP_CYCLES = 5000000,
    parameter int GAP_CYCLES  = 500000,
    parameter int MAX_STEPS   = 8
) (
    input  wire logic     clk,
    input  wire logic     rst,
    sfx_arbiter_if.slave  bus
);

    localparam int c_ID_W   = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1;
    localparam int c_TMR_W  = $clog2(STEP_CYCLES);
    localparam int c_STEP_W = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

    localparam logic [c_TMR_W-1:0]  c_TMR_LAST  = c_TMR_W'(STEP_CYCLES - 1);
    localparam logic [c_TMR_W-1:0]  c_TMR_PREV  = c_TMR_W'(STEP_CYCLES - 2);
    localparam logic [c_TMR_W-1:0]  c_GAP_START = c_TMR_W'(STEP_CYCLES - GAP_CYCLES);
    localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(MAX_STEPS - 1);

    arb_state_t          r_state, w_state_nxt;
    logic [NUM_SFX-1:0]  r_pend, w_pend_nxt, w_arb_pend, w_clr;
    logic [c_ID_W-1:0]   r_id, w_id_nxt, w_win, w_rom_id;
    logic [c_STEP_W-1:0] r_step, w_step_nxt, w_rom_step;
    logic [c_TMR_W-1:0]  r_timer, w_timer_nxt;
    logic [PHASE_W-1:0]  r_phase_inc, w_phase_nxt, w_rom_q;
    logic                r_note_gate, w_gate_nxt;
    logic                r_busy, r_done, w_done_nxt;
    logic                w_any, w_step_end, w_last;

    sfx_rom #(
        .ID_W   (c_ID_W),
        .STEP_W (c_STEP_W)
    ) u_rom (
        .clk       (clk),
        .id        (w_rom_id),
        .step      (w_rom_step),
        .phase_inc (w_rom_q)
    );

    always_comb begin
        w_step_end = (r_timer == c_TMR_LAST);
        // The ROM already holds the following entry on the last cycle of a step
        w_last     = w_step_end && ((r_step == c_STEP_LAST) || (w_rom_q == SFX_END));

        w_arb_pend = r_pend;
        if ((r_state == ST_PLAY || r_state == ST_GAP) && w_last)
            w_arb_pend = r_pend | bus.sfx_req;

        w_win = '0;
        w_any = 1'b0;
        for (int i = 0; i < NUM_SFX; i++) begin
            if (w_arb_pend[i]) begin
                w_win = c_ID_W'(i);
                w_any = 1'b1;
            end
        end

        w_state_nxt = r_state;
        w_id_nxt    = r_id;
        w_step_nxt  = r_step;
        w_timer_nxt = r_timer;
        w_clr       = '0;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt  = ST_LOAD;
                    w_id_nxt     = w_win;
                    w_clr[w_win] = 1'b1;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_PLAY;
            end
            default: begin
                if (w_last) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                    if (w_any) begin
                        w_state_nxt  = ST_LOAD;
                        w_id_nxt     = w_win;
                        w_clr[w_win] = 1'b1;
                    end
                end else if (w_any && (w_win >= r_id)) begin
                    // Abort or retrigger: the running effect is dropped, not re-queued
                    w_state_nxt  = ST_LOAD;
                    w_id_nxt     = w_win;
                    w_clr[w_win] = 1'b1;
                    w_clr[r_id]  = 1'b1;
                end else begin
                    if (w_step_end) begin
                        w_timer_nxt = '0;
                        w_step_nxt  = r_step + c_STEP_W'(1);
                    end else begin
                        w_timer_nxt = r_timer + c_TMR_W'(1);
                    end
                    w_state_nxt = (w_timer_nxt < c_GAP_START) ? ST_PLAY : ST_GAP;
                end
            end
        endcase

        if (w_state_nxt != ST_PLAY && w_state_nxt != ST_GAP) begin
            w_step_nxt  = '0;
            w_timer_nxt = '0;
        end

        w_pend_nxt = (r_pend | bus.sfx_req) & ~w_clr;

        if (!bus.enable) begin
            w_state_nxt = ST_IDLE;
            w_id_nxt    = '0;
            w_step_nxt  = '0;
            w_timer_nxt = '0;
            w_pend_nxt  = '0;
            w_done_nxt  = 1'b0;
        end
    end

    // ROM is addressed with the entry the output register needs one edge later
    always_comb begin
        w_rom_id    = r_id;
        w_rom_step  = r_step;
        w_phase_nxt = r_phase_inc;
        w_gate_nxt  = 1'b0;

        if (w_state_nxt == ST_LOAD) begin
            w_rom_id   = w_id_nxt;
            w_rom_step = '0;
        end else if (r_state == ST_LOAD) begin
            w_rom_step = '0;
        end else if ((r_timer >= c_TMR_PREV) && (r_step != c_STEP_LAST)) begin
            w_rom_step = r_step + c_STEP_W'(1);
        end

        case (w_state_nxt)
            ST_IDLE: begin
                w_phase_nxt = bus.mus_phase_inc;
                w_gate_nxt  = bus.mus_gate & ~bus.mute;
            end
            ST_PLAY: begin
                w_phase_nxt = w_rom_q;
                w_gate_nxt  = ~bus.mute;
            end
            ST_GAP: begin
                w_phase_nxt = w_rom_q;
            end
            default: ;
        endcase

        if (!bus.enable) begin
            w_phase_nxt = '0;
            w_gate_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pend      <= '0;
            r_id        <= '0;
            r_step      <= '0;
            r_timer     <= '0;
            r_phase_inc <= '0;
            r_note_gate <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend      <= w_pend_nxt;
            r_id        <= w_id_nxt;
            r_step      <= w_step_nxt;
            r_timer     <= w_timer_nxt;
            r_phase_inc <= w_phase_nxt;
            r_note_gate <= w_gate_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= w_done_nxt;
        end
    end

    assign bus.phase_inc = r_phase_inc;
    assign bus.note_gate = r_note_gate;
    assign bus.busy      = r_busy;
    assign bus.active_id = r_id;
    assign bus.sfx_done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sfx_arbiter.sv
// ============================================================================
//  Module      : tb_sfx_arbiter
//  Description : Directed and random stimulus for sfx_arbiter against an
//                effect-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sfx_arbiter;

    localparam int STEP = 20;
    localparam int GAP  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        mu  = 1'b0;
    logic        mg  = 1'b0;
    logic [3:0]  req = 4'd0;
    logic [31:0] mpi = 32'd0;

    int n_tests = 0;
    int n_fail  = 0;

    sfx_arbiter_if #(.NUM_SFX(4)) bus ();

    assign bus.enable        = en;
    assign bus.mute          = mu;
    assign bus.sfx_req       = req;
    assign bus.mus_phase_inc = mpi;
    assign bus.mus_gate      = mg;

    sfx_arbiter #(
        .NUM_SFX     (4),
        .STEP_CYCLES (STEP),
        .GAP_CYCLES  (GAP),
        .MAX_STEPS   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Effect note lists and lengths
    int          lens [4] = '{1, 2, 4, 5};
    logic [31:0] notes [4][5] = '{
        '{32'd46025675, 32'd0,        32'd0,        32'd0,        32'd0},
        '{32'd57988683, 32'd68960577, 32'd0,        32'd0,        32'd0},
        '{32'd46025675, 32'd57988683, 32'd68960577, 32'd92051350, 32'd0},
        '{32'd57988683, 32'd51662093, 32'd46025675, 32'd43442408, 32'd38702809}
    };

    // Model: mode 0 = music, 1 = loading, 2 = playing (m_age cycles into the effect)
    int          m_mode = 0;
    int          m_id   = 0;
    int          m_age  = 0;
    logic [3:0]  m_pend = 4'd0;
    logic [31:0] e_phase = 32'd0;
    logic        e_gate = 1'b0, e_busy = 1'b0, e_done = 1'b0;
    logic [1:0]  e_aid = 2'd0;

    function automatic int top_bit(input logic [3:0] v);
        int r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step();
        int go = -1;
        int abort_id = -1;
        if (rst || !en) begin
            m_mode = 0; m_pend = 4'd0; m_id = 0; m_age = 0;
            e_phase = 32'd0; e_gate = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_aid = 2'd0;
            return;
        end
        e_done = 1'b0;
        if (m_mode == 0) begin
            if (m_pend != 0) go = top_bit(m_pend);
        end else if (m_mode == 1) begin
            m_mode = 2;
            m_age  = 0;
        end else if (m_age + 1 == lens[m_id] * STEP) begin
            e_done = 1'b1;
            m_mode = 0;
            if ((m_pend | req) != 0) go = top_bit(m_pend | req);
        end else if (m_pend != 0 && top_bit(m_pend) >= m_id) begin
            go = top_bit(m_pend);
            abort_id = m_id;
        end else begin
            m_age++;
        end
        m_pend = m_pend | req;
        if (abort_id >= 0) m_pend[abort_id] = 1'b0;
        if (go >= 0) begin
            m_pend[go] = 1'b0;
            m_mode = 1;
            m_id   = go;
        end
        e_busy = (m_mode != 0);
        e_aid  = 2'(m_id);
        case (m_mode)
            0: begin e_phase = mpi; e_gate = mg & ~mu; end
            1: e_gate = 1'b0;
            default: begin
                e_phase = notes[m_id][m_age / STEP];
                e_gate  = ((m_age % STEP) < (STEP - GAP)) && !mu;
            end
        endcase
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then compare
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("phase_inc", bus.phase_inc, e_phase);
        chk("note_gate", 32'(bus.note_gate), 32'(e_gate));
        chk("busy",      32'(bus.busy),      32'(e_busy));
        chk("sfx_done",  32'(bus.sfx_done),  32'(e_done));
        chk("active_id", 32'(bus.active_id), 32'(e_aid));
    endtask

    task automatic pulse(input logic [3:0] v);
        req = v;
        tick();
        req = 4'd0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin : stim
        int g_hi, n_done, seen_drop;

        // Reset state
        run(3);
        chk("rst_phase", bus.phase_inc, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;

        // Idle pass-through
        en = 1'b1; mpi = 32'd46025675; mg = 1'b1;
        tick();
        chk("idle_phase", bus.phase_inc, 32'd46025675);
        chk("idle_gate", 32'(bus.note_gate), 32'd1);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        run(5);

        // LINE: four notes, 16 gate-high cycles each, one done pulse
        mpi = 32'd12345;
        tick();
        pulse(4'b0100);
        tick();
        chk("line_busy", 32'(bus.busy), 32'd1);
        chk("line_aid", 32'(bus.active_id), 32'd2);
        g_hi = 0; n_done = 0;
        for (int i = 0; i < 90; i++) begin
            tick();
            if (i == 0) begin
                chk("line_c5", bus.phase_inc, 32'd46025675);
                chk("line_gate0", 32'(bus.note_gate), 32'd1);
            end
            if (i == 60) chk("line_c6", bus.phase_inc, 32'd92051350);
            if (bus.busy && bus.note_gate) g_hi++;
            if (bus.sfx_done) n_done++;
        end
        chk("line_gate_cycles", 32'(g_hi), 32'd64);
        chk("line_done_count", 32'(n_done), 32'd1);
        chk("line_music_back", bus.phase_inc, 32'd12345);

        // Preemption: GAMEOVER interrupts DROP at step 0 cycle 5
        pulse(4'b0001);
        run(6);
        pulse(4'b1000);
        tick();
        chk("pre_aid", 32'(bus.active_id), 32'd3);
        tick();
        chk("pre_e5", bus.phase_inc, 32'd57988683);
        n_done = 0;
        for (int i = 0; i < 110; i++) begin
            tick();
            if (bus.sfx_done) begin
                n_done++;
                chk("pre_done_id", 32'(bus.active_id), 32'd3);
            end
        end
        chk("pre_done_count", 32'(n_done), 32'd1);

        // Pending ROTATE follows LINE without an idle cycle
        pulse(4'b0100);
        run(10);
        pulse(4'b0010);
        for (int i = 0; i < 130; i++) begin
            tick();
            if (bus.sfx_done && bus.active_id == 2'd2) chk("pend_busy_held", 32'(bus.busy), 32'd1);
        end

        // Simultaneous DROP + ROTATE: ROTATE first, then DROP
        pulse(4'b0011);
        tick();
        chk("sim_first", 32'(bus.active_id), 32'd1);
        seen_drop = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (bus.busy && bus.active_id == 2'd0) seen_drop = 1;
        end
        chk("sim_then_drop", 32'(seen_drop), 32'd1);

        // Mute mid-effect
        pulse(4'b0100);
        run(2);
        mu = 1'b1;
        g_hi = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.note_gate) g_hi++;
        end
        chk("mute_gate", 32'(g_hi), 32'd0);
        mu = 1'b0;
        run(70);

        // Enable low mid-effect clears pending work
        pulse(4'b0100);
        run(5);
        pulse(4'b0001);
        en = 1'b0;
        tick();
        chk("dis_phase", bus.phase_inc, 32'd0);
        chk("dis_busy", 32'(bus.busy), 32'd0);
        en = 1'b1;
        g_hi = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.busy) g_hi++;
        end
        chk("dis_pend_cleared", 32'(g_hi), 32'd0);

        // Reset mid-effect
        pulse(4'b1000);
        run(10);
        rst = 1'b1;
        tick();
        chk("mrst_phase", bus.phase_inc, 32'd0);
        chk("mrst_gate", 32'(bus.note_gate), 32'd0);
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_aid", 32'(bus.active_id), 32'd0);
        rst = 1'b0;
        run(3);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            req = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            if ($urandom_range(0, 199) == 0) mu = ~mu;
            en  = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 15) == 0) begin
                mpi = $urandom;
                mg  = 1'($urandom_range(0, 1));
            end
            tick();
        end
        req = 4'd0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sfx_arbiter.md
Name: sfx_arbiter

Overview:
- Shares the single tone_gen/pwm_dac audio path between the background-music note sequencer and short game sound effects: piece drop, rotate, line clear and game over.
- Game logic issues one-cycle request pulses. The block plays the selected effect's note list from a small ROM, preempting music, and otherwise passes the sequencer's phase_inc/note_gate through.
- Sits between note_sequencer and tone_gen in the audio top.

Parameters:
- NUM_SFX, 4, number of effect sources; index = priority, highest wins.
- STEP_CYCLES, 5000000, clk cycles per effect note (50 ms at 100 MHz).
- GAP_CYCLES, 500000, silent tail of each step; requires GAP_CYCLES < STEP_CYCLES.
- MAX_STEPS, 8, maximum notes per effect.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  audio enable (switch); low forces idle.
- mute  in  1  forces note_gate low; sequencing continues.
- sfx_req  in  NUM_SFX  one-cycle request pulses, one bit per effect.
- mus_phase_inc  in  32  music phase increment from note_sequencer.
- mus_gate  in  1  music note gate from note_sequencer.
- phase_inc  out  32  to tone_gen.
- note_gate  out  1  sample gate to DAC mux.
- busy  out  1  an effect is playing.
- active_id  out  clog2(NUM_SFX)  effect currently playing.
- sfx_done  out  1  one-cycle pulse when an effect completes normally.

Behaviour:
- Reset values: all outputs are registered and reset to 0. Pending bits and timers are cleared. FSM goes to IDLE. A reset mid-effect takes effect at the next edge.
- FSM states: IDLE, LOAD, PLAY, GAP.
- IDLE:
  - phase_inc <= mus_phase_inc.
  - note_gate <= mus_gate & ~mute (1-cycle latency).
  - busy = 0.
- Request capture: any sfx_req bit sets its pending bit on the same edge.
- Arbitration:
  - When any pending bit is set, select the highest index, clear its pending bit and go to LOAD.
  - LOAD issues the ROM read (1-cycle registered read) for step 0, then enters PLAY.
  - Request pulse at edge k → busy=1 and active_id valid at edge k+1 → phase_inc = ROM step 0 and note_gate=1 at edge k+2.
- PLAY/GAP timing:
  - The step timer counts 0..STEP_CYCLES-1.
  - note_gate = ~mute during PLAY, i.e. timer < STEP_CYCLES-GAP_CYCLES, then 0 in GAP.
  - At timer = STEP_CYCLES-1, the step index increments and the next ROM entry is used.
  - No extra dead cycle between steps: the ROM read for step+1 is issued one cycle early.
- Termination: an effect ends when the next ROM entry is 0 (end marker) or step index = MAX_STEPS-1 completes.
  - Then sfx_done pulses for 1 cycle, busy drops, and the FSM returns to IDLE (music resumes next cycle).
  - If another bit is pending, the FSM goes straight to LOAD instead and busy stays 1.
- Preemption and retrigger while busy:
  - Request with index > active_id: abort the current effect with no sfx_done, clear that effect's state (not re-queued), and LOAD the new effect.
  - Request with index = active_id: restart from step 0 (through LOAD).
  - Request with index < active_id: set its pending bit; it is served after completion.
- Simultaneous requests: the highest index wins; the rest stay pending. A request arriving on the same edge as a completion is included in that completion's arbitration.
- enable low: behaves as a soft reset. Pending bits are cleared, the FSM goes to IDLE, and phase_inc and note_gate are held at 0.
- mute is honoured in every state.
- Widths: timer is clog2(STEP_CYCLES) bits; step index is clog2(MAX_STEPS) bits. Neither may wrap silently; the end condition is checked first.

Decomposition:
- Package audio_pkg holds:
  - Note phase-increment constants at 48.8 kHz: A4, B4, C5, D5, E5, F5, G5, A5, C6 = 92051350.
  - SFX ids: SFX_DROP=0, SFX_ROTATE=1, SFX_LINE=2, SFX_GAMEOVER=3.
  - SFX_END = 0.
- One sub-module, sfx_rom:
  - Inputs: id and step. Output: registered 32-bit phase_inc.
  - Contents: DROP={C5}, ROTATE={E5,G5}, LINE={C5,E5,G5,C6}, GAMEOVER={E5,D5,C5,B4,A4}.

Test Plan:
Run with STEP_CYCLES=20, GAP_CYCLES=4.
- Idle pass-through: mus_phase_inc=46025675, mus_gate=1 → phase_inc=46025675 and note_gate=1 one cycle later; busy=0.
- LINE request (sfx_req=4'b0100) at cycle 10 → cycle 12: phase_inc=C5, note_gate=1. Four steps C5/E5/G5/C6, each with 16 gate-high and 4 gate-low cycles. sfx_done pulses once, then music resumes.
- Preemption: DROP playing, GAMEOVER requested at step 0 cycle 5 → GAMEOVER step 0 (E5) within 2 cycles; DROP never raises sfx_done.
- Pending: LINE playing, ROTATE pulsed → ROTATE starts right after LINE's sfx_done with no IDLE cycle; busy stays 1.
- Simultaneous sfx_req=4'b0011 → ROTATE plays first, then DROP.
- Control mid-effect:
  - mute=1 → note_gate=0 while steps keep advancing.
  - enable=0 → next cycle phase_inc=0, busy=0, pending cleared.
  - rst=1 → all outputs 0 next cycle.
